// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count,
// sticky overflow/underflow flags and a selectable first-word-fall-through read mode.
module sync_fifo_thr #(
  parameter int Data_Width = 8,
  parameter int Depth      = 256,
  parameter int Addr_Width = 8,
  parameter int AF_Thr     = Depth - 4,
  parameter int AE_Thr     = 4,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [Data_Width-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [Data_Width-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [Addr_Width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = Addr_Width + 1;
  localparam logic [PW-1:0] AfThrC = PW'(AF_Thr);
  localparam logic [PW-1:0] AeThrC = PW'(AE_Thr);

  logic [Data_Width-1:0] mem_q [Depth];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d, occ_old_s;
  logic [Data_Width-1:0] data_out_q;
  logic                  rd_valid_q, full_q, empty_q, almost_full_q, almost_empty_q;
  logic                  overflow_q, underflow_q;
  logic                  rd_ok_s, rd_acc_s, wr_acc_s, ovf_evt_s, unf_evt_s;

  // In FWFT mode a pop needs a presented head; a word written into an empty FIFO
  // is not yet presented in the cycle after its write.
  assign rd_ok_s   = FWFT ? rd_valid_q : !empty_q;
  assign rd_acc_s  = !rst && rd_en && rd_ok_s;
  assign wr_acc_s  = !rst && wr_en && (!full_q || rd_acc_s);
  assign ovf_evt_s = !rst && wr_en && full_q && !rd_acc_s;
  assign unf_evt_s = !rst && rd_en && !rd_ok_s;

  assign wr_ptr_d  = wr_ptr_q + {{Addr_Width{1'b0}}, wr_acc_s};
  assign rd_ptr_d  = rd_ptr_q + {{Addr_Width{1'b0}}, rd_acc_s};
  assign count_d   = wr_ptr_d - rd_ptr_d;
  // Entries already in storage before this edge's write, after this edge's pop.
  assign occ_old_s = count_q - {{Addr_Width{1'b0}}, rd_acc_s};

  // Storage array write port; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q[Addr_Width-1:0]] <= data_in;
    end
  end

  // Pointers, registered flags, read output stage and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= {PW{1'b0}};
      rd_ptr_q       <= {PW{1'b0}};
      count_q        <= {PW{1'b0}};
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      data_out_q     <= {Data_Width{1'b0}};
      rd_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= (wr_ptr_d[Addr_Width] != rd_ptr_d[Addr_Width]) &&
                        (wr_ptr_d[Addr_Width-1:0] == rd_ptr_d[Addr_Width-1:0]);
      empty_q        <= (wr_ptr_d == rd_ptr_d);
      almost_full_q  <= (count_d >= AfThrC);
      almost_empty_q <= (count_d <= AeThrC);
      overflow_q     <= ovf_evt_s || (overflow_q && !err_clr);
      underflow_q    <= unf_evt_s || (underflow_q && !err_clr);
      if (FWFT) begin
        data_out_q <= mem_q[rd_ptr_d[Addr_Width-1:0]];
        rd_valid_q <= (occ_old_s != {PW{1'b0}});
      end else begin
        if (rd_acc_s) begin
          data_out_q <= mem_q[rd_ptr_q[Addr_Width-1:0]];
        end else begin
          data_out_q <= data_out_q;
        end
        rd_valid_q <= rd_acc_s;
      end
    end
  end

  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Bench for sync_fifo_thr: a standard-mode and an FWFT-mode instance, each stepped
// cycle by cycle against a queue-based reference model of the FIFO's behaviour.
module tb_sync_fifo_thr;

  logic       clk = 1'b0;
  logic       s_rst = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0, s_err_clr = 1'b0;
  logic [7:0] s_data_in = 8'h00, s_data_out;
  logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0] s_count;
  logic       f_rst = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0, f_err_clr = 1'b0;
  logic [7:0] f_data_in = 8'h00, f_data_out;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  int    checks = 0;
  int    failures = 0;
  string cur_test = "none";

  // reference model state
  logic [7:0] qs[$];
  logic [7:0] qf[$];
  logic       ovf_s_m, unf_s_m, val_s_m, ovf_f_m, unf_f_m, val_f_m;
  logic [7:0] dout_s_m;

  always #5 clk = ~clk;

  sync_fifo_thr #(.Data_Width(8), .Depth(16), .Addr_Width(4), .AF_Thr(12), .AE_Thr(4), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .data_in(s_data_in), .rd_en(s_rd_en), .err_clr(s_err_clr),
    .data_out(s_data_out), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf));

  sync_fifo_thr #(.Data_Width(8), .Depth(16), .Addr_Width(4), .AF_Thr(12), .AE_Thr(4), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en), .err_clr(f_err_clr),
    .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf));

  // One standard-mode cycle: drive, advance the model, compare after the edge.
  task automatic cyc_s(input logic wr, input logic [7:0] d, input logic rd, input logic clr, input logic rs);
    logic full_m, empty_m, rda, wra;
    logic [10:0] exp_st, got_st;
    int n;
    @(negedge clk);
    s_rst = rs; s_wr_en = wr; s_data_in = d; s_rd_en = rd; s_err_clr = clr;
    if (rs) begin
      qs.delete(); ovf_s_m = 1'b0; unf_s_m = 1'b0; val_s_m = 1'b0; dout_s_m = 8'h00;
    end else begin
      full_m  = (qs.size() == 16);
      empty_m = (qs.size() == 0);
      rda = rd && !empty_m;
      wra = wr && (!full_m || rda);
      ovf_s_m = (wr && full_m && !rda) || (ovf_s_m && !clr);
      unf_s_m = (rd && empty_m) || (unf_s_m && !clr);
      val_s_m = rda;
      if (rda) dout_s_m = qs.pop_front();
      if (wra) qs.push_back(d);
    end
    @(posedge clk); #1;
    n = qs.size();
    exp_st = {5'(n), n == 16, n == 0, n >= 12, n <= 4, ovf_s_m, unf_s_m};
    got_st = {s_count, s_full, s_empty, s_af, s_ae, s_ovf, s_unf};
    checks++;
    if (got_st !== exp_st) begin
      failures++;
      $display("FAIL %s std_status got=%b exp=%b (count,full,empty,af,ae,ovf,unf)", cur_test, got_st, exp_st);
    end
    checks++;
    if (s_rd_valid !== val_s_m || s_data_out !== dout_s_m) begin
      failures++;
      $display("FAIL %s std_read got valid=%b data=%h exp valid=%b data=%h", cur_test, s_rd_valid, s_data_out, val_s_m, dout_s_m);
    end
    s_wr_en = 1'b0; s_rd_en = 1'b0; s_err_clr = 1'b0; s_rst = 1'b0;
  endtask

  // One FWFT-mode cycle: a word is presented once it has sat in storage for one edge.
  task automatic cyc_f(input logic wr, input logic [7:0] d, input logic rd, input logic clr, input logic rs);
    logic full_m, rda, wra;
    logic [10:0] exp_st, got_st;
    int n;
    @(negedge clk);
    f_rst = rs; f_wr_en = wr; f_data_in = d; f_rd_en = rd; f_err_clr = clr;
    if (rs) begin
      qf.delete(); ovf_f_m = 1'b0; unf_f_m = 1'b0; val_f_m = 1'b0;
    end else begin
      full_m = (qf.size() == 16);
      rda = rd && val_f_m;
      wra = wr && (!full_m || rda);
      ovf_f_m = (wr && full_m && !rda) || (ovf_f_m && !clr);
      unf_f_m = (rd && !val_f_m) || (unf_f_m && !clr);
      if (rda) void'(qf.pop_front());
      val_f_m = (qf.size() > 0);
      if (wra) qf.push_back(d);
    end
    @(posedge clk); #1;
    n = qf.size();
    exp_st = {5'(n), n == 16, n == 0, n >= 12, n <= 4, ovf_f_m, unf_f_m};
    got_st = {f_count, f_full, f_empty, f_af, f_ae, f_ovf, f_unf};
    checks++;
    if (got_st !== exp_st) begin
      failures++;
      $display("FAIL %s fwft_status got=%b exp=%b (count,full,empty,af,ae,ovf,unf)", cur_test, got_st, exp_st);
    end
    checks++;
    if (f_rd_valid !== val_f_m) begin
      failures++;
      $display("FAIL %s fwft_valid got=%b exp=%b", cur_test, f_rd_valid, val_f_m);
    end
    if (val_f_m) begin
      checks++;
      if (f_data_out !== qf[0]) begin
        failures++;
        $display("FAIL %s fwft_head got=%h exp=%h", cur_test, f_data_out, qf[0]);
      end
    end
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0; f_rst = 1'b0;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    cyc_s(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    cyc_f(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    checks++;
    if (s_data_out !== 8'h00 || s_count !== 5'd0 || s_empty !== 1'b1 || s_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset std_values got data=%h count=%0d empty=%b valid=%b exp 00/0/1/0", s_data_out, s_count, s_empty, s_rd_valid);
    end
    checks++;
    if (f_data_out !== 8'h00 || f_count !== 5'd0 || f_empty !== 1'b1 || f_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset fwft_values got data=%h count=%0d empty=%b valid=%b exp 00/0/1/0", f_data_out, f_count, f_empty, f_rd_valid);
    end
  endtask

  task automatic test_fill_drain();
    cur_test = "fill_drain";
    for (int i = 0; i < 16; i++) cyc_s(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (s_full !== 1'b1 || s_count !== 5'd16) begin
      failures++;
      $display("FAIL fill_drain full got full=%b count=%0d exp 1/16", s_full, s_count);
    end
    for (int i = 0; i < 16; i++) begin
      cyc_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (s_data_out !== 8'(i)) begin
        failures++;
        $display("FAIL fill_drain order got=%h exp=%h", s_data_out, 8'(i));
      end
    end
    checks++;
    if (s_empty !== 1'b1) begin
      failures++;
      $display("FAIL fill_drain empty got=%b exp=1", s_empty);
    end
  endtask

  task automatic test_errors();
    cur_test = "errors";
    for (int i = 0; i < 16; i++) cyc_s(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    cyc_s(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    checks++;
    if (s_ovf !== 1'b1 || s_count !== 5'd16) begin
      failures++;
      $display("FAIL errors overflow got ovf=%b count=%0d exp 1/16", s_ovf, s_count);
    end
    for (int i = 0; i < 16; i++) cyc_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (s_unf !== 1'b1) begin
      failures++;
      $display("FAIL errors underflow got=%b exp=1", s_unf);
    end
    cyc_s(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc_s(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin
      failures++;
      $display("FAIL errors clear got ovf=%b unf=%b exp 0/0", s_ovf, s_unf);
    end
  endtask

  task automatic test_full_simul();
    cur_test = "full_simul";
    for (int i = 0; i < 16; i++) cyc_s(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    cyc_s(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (s_full !== 1'b1 || s_count !== 5'd16 || s_ovf !== 1'b0) begin
      failures++;
      $display("FAIL full_simul flags got full=%b count=%0d ovf=%b exp 1/16/0", s_full, s_count, s_ovf);
    end
    for (int i = 0; i < 16; i++) cyc_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (s_data_out !== 8'hC3) begin
      failures++;
      $display("FAIL full_simul last got=%h exp=c3", s_data_out);
    end
  endtask

  task automatic test_wrap();
    cur_test = "wrap";
    for (int i = 0; i < 3; i++) cyc_s(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc_s(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    cur_test = "mid_reset";
    for (int i = 0; i < 7; i++) cyc_s(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    cyc_s(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (s_count !== 5'd0 || s_empty !== 1'b1 || s_rd_valid !== 1'b0 || s_ovf !== 1'b0 || s_unf !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset state got count=%0d empty=%b valid=%b ovf=%b unf=%b", s_count, s_empty, s_rd_valid, s_ovf, s_unf);
    end
    cyc_s(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    cyc_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (s_data_out !== 8'h99 || s_empty !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset new_data got data=%h empty=%b exp 99/1", s_data_out, s_empty);
    end
  endtask

  task automatic test_random_std();
    cur_test = "random_std";
    for (int i = 0; i < 400; i++)
      cyc_s(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 19) == 0), 1'b0);
  endtask

  task automatic test_fwft();
    cur_test = "fwft";
    cyc_f(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    cyc_f(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (f_rd_valid !== 1'b1 || f_data_out !== 8'h5A) begin
      failures++;
      $display("FAIL fwft first_word got valid=%b data=%h exp 1/5a", f_rd_valid, f_data_out);
    end
    cyc_f(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc_f(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    cyc_f(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    cyc_f(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 3; i++) begin
      cyc_f(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (f_rd_valid !== 1'b1 || f_data_out !== 8'(i)) begin
        failures++;
        $display("FAIL fwft back_to_back got valid=%b data=%h exp 1/%h", f_rd_valid, f_data_out, 8'(i));
      end
    end
    cyc_f(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (f_rd_valid !== 1'b0 || f_empty !== 1'b1) begin
      failures++;
      $display("FAIL fwft drained got valid=%b empty=%b exp 0/1", f_rd_valid, f_empty);
    end
    cur_test = "random_fwft";
    for (int i = 0; i < 400; i++)
      cyc_f(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 19) == 0), 1'b0);
  endtask

  initial begin
    ovf_s_m = 1'b0; unf_s_m = 1'b0; val_s_m = 1'b0; dout_s_m = 8'h00;
    ovf_f_m = 1'b0; unf_f_m = 1'b0; val_f_m = 1'b0;
    test_reset();
    test_fill_drain();
    test_errors();
    test_full_simul();
    test_wrap();
    test_mid_reset();
    test_random_std();
    test_fwft();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
